// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
package clk_div_pkg;

    typedef enum logic {
        MODE_SQUARE = 1'b0,
        MODE_PULSE  = 1'b1
    } mode_e;

    localparam int MIN_DIV = 2;

    // Width of a channel index; never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, staged/active config and registered out/tick decode.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_div,
    input  logic             wr_mode,
    output logic             pending,
    output logic             out,
    output logic             tick
);

    logic [WIDTH-1:0] cnt_q, cnt_d, div_q, div_d, stg_div_q, stg_div_d;
    mode_e            mode_q, mode_d, stg_mode_q, stg_mode_d;
    logic             run_q, run_d, pend_q, pend_d;
    logic             out_q, out_d, tick_q, tick_d;
    logic             at_end, boundary;

    always_comb begin
        run_d      = en;
        cnt_d      = '0;
        div_d      = div_q;
        mode_d     = mode_q;
        stg_div_d  = stg_div_q;
        stg_mode_d = stg_mode_q;
        pend_d     = pend_q;

        // Phase 0 is re-entered on wrap, sync, disable, or the first enabled cycle.
        at_end   = run_q && (cnt_q == div_q - 1'b1);
        boundary = !en || sync || !run_q || at_end;
        if (!boundary)
            cnt_d = cnt_q + 1'b1;

        if (boundary && pend_q) begin
            div_d  = stg_div_q;
            mode_d = stg_mode_q;
            pend_d = 1'b0;
        end
        // A write landing on a boundary stays staged for the next one.
        if (wr) begin
            stg_div_d  = wr_div;
            stg_mode_d = mode_e'(wr_mode);
            pend_d     = 1'b1;
        end

        tick_d = en && (cnt_d == div_d - 1'b1);
        out_d  = en && ((mode_d == MODE_PULSE) ? tick_d : (cnt_d < (div_d >> 1)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            run_q      <= 1'b0;
            div_q      <= WIDTH'(DEFAULT_DIV);
            mode_q     <= MODE_SQUARE;
            stg_div_q  <= '0;
            stg_mode_q <= MODE_SQUARE;
            pend_q     <= 1'b0;
            out_q      <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            run_q      <= run_d;
            div_q      <= div_d;
            mode_q     <= mode_d;
            stg_div_q  <= stg_div_d;
            stg_mode_q <= stg_mode_d;
            pend_q     <= pend_d;
            out_q      <= out_d;
            tick_q     <= tick_d;
        end
    end

    assign pending = pend_q;
    assign out     = out_q;
    assign tick    = tick_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider with shared config bus and global sync.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter  int CHANNELS    = 2,
    parameter  int WIDTH       = 16,
    parameter  int DEFAULT_DIV = 6,
    localparam int CHW         = clog2_min1(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] en,
    input  logic                sync,
    input  logic                cfg_we,
    input  logic [CHW-1:0]      cfg_ch,
    input  logic [WIDTH-1:0]    cfg_div,
    input  logic                cfg_mode,
    output logic                cfg_err,
    output logic [CHANNELS-1:0] pending,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] tick
);

    logic wr_ok, cfg_err_q, cfg_err_d;

    assign wr_ok     = cfg_we && (cfg_div >= WIDTH'(MIN_DIV)) && (32'(cfg_ch) < CHANNELS);
    assign cfg_err_d = cfg_we && !wr_ok;

    always_ff @(posedge clk) begin
        if (rst) cfg_err_q <= 1'b0;
        else     cfg_err_q <= cfg_err_d;
    end

    assign cfg_err = cfg_err_q;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        clk_div_chan #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .en      (en[c]),
            .sync    (sync),
            .wr      (wr_ok && (cfg_ch == CHW'(c))),
            .wr_div  (cfg_div),
            .wr_mode (cfg_mode),
            .pending (pending[c]),
            .out     (out[c]),
            .tick    (tick[c])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed + random bench for clk_div_multi against a cycle-level reference model.
module tb_clk_div_multi;

    localparam int CH  = 3;
    localparam int W   = 4;
    localparam int DEF = 6;
    localparam int CHW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] en;
    logic          sync, cfg_we, cfg_mode, cfg_err;
    logic [CHW-1:0] cfg_ch;
    logic [W-1:0]  cfg_div;
    logic [CH-1:0] pending, out, tick;

    int n_vec = 0;
    int n_bad = 0;

    // Reference state: phase within period, period length, mode, staged config.
    int m_run[CH], m_cnt[CH], m_div[CH], m_md[CH], m_sdiv[CH], m_smd[CH], m_pnd[CH];
    int m_err;

    clk_div_multi #(.CHANNELS(CH), .WIDTH(W), .DEFAULT_DIV(DEF)) dut (
        .clk(clk), .rst(rst), .en(en), .sync(sync), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .cfg_mode(cfg_mode), .cfg_err(cfg_err), .pending(pending),
        .out(out), .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic model_update();
        bit acc, at_end, bnd;
        if (rst) begin
            for (int c = 0; c < CH; c++) begin
                m_run[c] = 0; m_cnt[c] = 0; m_div[c] = DEF; m_md[c] = 0;
                m_sdiv[c] = 0; m_smd[c] = 0; m_pnd[c] = 0;
            end
            m_err = 0;
        end else begin
            acc   = cfg_we && (int'(cfg_div) >= 2) && (int'(cfg_ch) < CH);
            m_err = (cfg_we && !acc) ? 1 : 0;
            for (int c = 0; c < CH; c++) begin
                at_end = (m_run[c] != 0) && (m_cnt[c] == m_div[c] - 1);
                bnd    = !en[c] || sync || (m_run[c] == 0) || at_end;
                m_cnt[c] = bnd ? 0 : m_cnt[c] + 1;
                m_run[c] = en[c] ? 1 : 0;
                if (bnd && m_pnd[c] != 0) begin
                    m_div[c] = m_sdiv[c]; m_md[c] = m_smd[c]; m_pnd[c] = 0;
                end
                if (acc && int'(cfg_ch) == c) begin
                    m_sdiv[c] = int'(cfg_div); m_smd[c] = int'(cfg_mode); m_pnd[c] = 1;
                end
            end
        end
    endtask

    task automatic check();
        logic [CH-1:0] eo, et, ep;
        for (int c = 0; c < CH; c++) begin
            et[c] = (m_run[c] != 0) && (m_cnt[c] == m_div[c] - 1);
            eo[c] = (m_run[c] != 0) && ((m_md[c] != 0) ? et[c] : (m_cnt[c] < m_div[c] / 2));
            ep[c] = (m_pnd[c] != 0);
        end
        n_vec++;
        assert (out === eo) else begin n_bad++; $error("FAIL out got=%b exp=%b t=%0t", out, eo, $time); end
        assert (tick === et) else begin n_bad++; $error("FAIL tick got=%b exp=%b t=%0t", tick, et, $time); end
        assert (pending === ep) else begin n_bad++; $error("FAIL pending got=%b exp=%b t=%0t", pending, ep, $time); end
        assert (cfg_err === m_err[0]) else begin n_bad++; $error("FAIL cfg_err got=%b exp=%b t=%0t", cfg_err, m_err[0], $time); end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_update();
            #1;
            check();
            sync = 1'b0;
            cfg_we = 1'b0;
        end
    endtask

    task automatic wr(input int ch, input int dv, input bit md);
        cfg_we = 1'b1; cfg_ch = CHW'(ch); cfg_div = W'(dv); cfg_mode = md;
        step(1);
    endtask

    initial begin
        logic [5:0] exp_o, exp_t, got_o, got_t;
        int guard;
        rst = 1'b1; en = '0; sync = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_mode = 1'b0;
        step(2);

        // First period at default divisor: 3 high, 3 low, tick on the last cycle.
        rst = 1'b0; en = '1;
        exp_o = 6'b000111; exp_t = 6'b100000;
        for (int i = 0; i < 6; i++) begin
            step(1);
            got_o[i] = out[0]; got_t[i] = tick[0];
        end
        n_vec++;
        assert (got_o === exp_o && got_t === exp_t) else begin
            n_bad++; $error("FAIL first_period out=%b tick=%b exp out=%b tick=%b", got_o, got_t, exp_o, exp_t);
        end
        step(8);

        wr(1, 4, 1'b1);
        step(14);

        wr(0, 1, 1'b0);
        step(1);
        wr(3, 5, 1'b1);
        step(3);

        wr(1, 6, 1'b0);
        step(12);
        sync = 1'b1;
        step(10);

        // Land a write exactly on ch0's wrap cycle.
        guard = 0;
        while (m_cnt[0] != m_div[0] - 1 && guard < 20) begin step(1); guard++; end
        n_vec++;
        assert (guard < 20) else begin n_bad++; $error("FAIL wrap_wait got=%0d exp<20", guard); end
        wr(0, 3, 1'b0);
        step(14);

        wr(2, 15, 1'b0);
        step(34);

        wr(0, 5, 1'b1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(10);

        en = 3'b101;
        step(4);
        wr(1, 2, 1'b0);
        step(2);
        en = '1;
        step(6);

        for (int i = 0; i < 400; i++) begin
            en   = ($urandom_range(0, 9) == 0) ? CH'($urandom) : '1;
            sync = ($urandom_range(0, 14) == 0);
            rst  = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 3) == 0) begin
                cfg_we = 1'b1; cfg_ch = CHW'($urandom_range(0, 3));
                cfg_div = W'($urandom_range(0, 15)); cfg_mode = $urandom_range(0, 1) != 0;
            end
            step(1);
            rst = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
